bus_arbiter_rr: RTL and testbench

//  Round-robin arbiter for the shared system bus between the CPU bus interfaces (IF fetch, MEM data)
//  and other bus masters. Grants ownership to one master at a time.

---
 rtl/bus_arbiter_rr.sv | 162 ++++++++++++++++
 tb/tb_bus_arbiter_rr.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_rr.sv
// -----------------------------------------------------------------------------
// bus_arbiter_rr
//   Round-robin arbiter for the shared system bus. It grants the bus to one
//   master at a time. The owner keeps the bus for as long as it holds its
//   request. When ownership ends, the round-robin pointer moves to the slot
//   after the last owner, so that owner has the lowest priority next time.
//
//   Optional feature (macro ARB_TIMEOUT_EN):
//     An owner that has held the bus for MAX_HOLD cycles is forced to hand the
//     bus to the next requester, and preempt pulses for one cycle. A sole
//     requester is never preempted. When the macro is not defined, the hold
//     counter is not built and preempt is tied low.
//
// Parameters
//   ID_W      owner id width; number of masters N = 2**ID_W
//   MAX_HOLD  cycles of ownership before a forced hand-off (>= 2)
//
// Ports
//   clk       system clock, all state on rising edge
//   reset     asynchronous, active-low reset
//   req       per-master level request, N bits
//   grnt      one-hot registered grant, all-zero = bus idle
//   owner_id  index of current / last owner
//   bus_busy  OR of grnt
//   preempt   1-cycle pulse after a timeout hand-off
// -----------------------------------------------------------------------------
module bus_arbiter_rr #(
  parameter int ID_W     = 2,
  parameter int MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2**ID_W-1:0]   req,
  output logic [2**ID_W-1:0]   grnt,
  output logic [ID_W-1:0]      owner_id,
  output logic                 bus_busy,
  output logic                 preempt
);

  localparam int N = 2**ID_W;

  typedef enum logic {IDLE, OWN} state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   owner_q, owner_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   owner_inc;
  logic [N-1:0]      own_mask;
  logic              others;

`ifdef ARB_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD) + 1;
  localparam logic [HOLD_W-1:0] HOLD_SAT = HOLD_W'(MAX_HOLD - 1);

  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              preempt_q, preempt_d;
`endif

  // First requester found scanning p, p+1, ... with wrap-around.
  function automatic logic [ID_W-1:0] pick(input logic [N-1:0] r,
                                           input logic [ID_W-1:0] p);
    logic [ID_W-1:0] idx;
    logic            found;
    pick  = p;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = p + ID_W'(i);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  endfunction

  assign own_mask  = N'(1) << owner_q;
  assign owner_inc = owner_q + 1'b1;
  // Requests from any master other than the current owner.
  assign others    = |(req & ~own_mask);

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
`ifdef ARB_TIMEOUT_EN
    hold_cnt_d = hold_cnt_q;
    preempt_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = OWN;
          owner_d = pick(req, rr_ptr_q);
`ifdef ARB_TIMEOUT_EN
          hold_cnt_d = '0;
`endif
        end
      end
      OWN: begin
        if (req[owner_q]) begin
`ifdef ARB_TIMEOUT_EN
          if (hold_cnt_q == HOLD_SAT && others) begin
            // Forced hand-off. The preempted owner's request stays pending
            // and is served again in round-robin order.
            owner_d    = pick(req, owner_inc);
            rr_ptr_d   = owner_inc;
            hold_cnt_d = '0;
            preempt_d  = 1'b1;
          end else if (hold_cnt_q != HOLD_SAT) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
`endif
        end else if (others) begin
          // Direct hand-off with no idle cycle in between.
          owner_d  = pick(req, owner_inc);
          rr_ptr_d = owner_inc;
`ifdef ARB_TIMEOUT_EN
          hold_cnt_d = '0;
`endif
        end else begin
          // owner_id keeps the last owner while the bus is idle.
          state_d  = IDLE;
          rr_ptr_d = owner_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_cnt_q <= '0;
      preempt_q  <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      preempt_q  <= preempt_d;
    end
  end
  assign preempt = preempt_q;
`else
  assign preempt = 1'b0;
`endif

  // Grant is decoded from flops only, so it is glitch-free and clears
  // immediately with the asynchronous reset.
  assign grnt     = (state_q == OWN) ? own_mask : '0;
  assign bus_busy = (state_q == OWN);
  assign owner_id = owner_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter_rr
//   Self-checking bench for bus_arbiter_rr (ID_W=2, MAX_HOLD=16). Each
//   clocked step pushes the expected {grnt, owner_id, bus_busy, preempt}
//   onto a queue and pops it for comparison on the following falling edge.
// -----------------------------------------------------------------------------
module tb_bus_arbiter_rr;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic [3:0] grnt;
  logic [1:0] owner_id;
  logic       bus_busy;
  logic       preempt;

  int passed;
  int total;

  typedef struct packed {
    logic [3:0] g;
    logic [1:0] o;
    logic       p;
  } exp_t;

  typedef struct packed {
    logic [3:0] req;
    logic [3:0] g;
    logic [1:0] o;
  } vec_t;

  exp_t exp_q[$];
  vec_t tbl[19];

  bus_arbiter_rr #(.ID_W(2), .MAX_HOLD(16)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .grnt     (grnt),
    .owner_id (owner_id),
    .bus_busy (bus_busy),
    .preempt  (preempt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got grnt/owner/busy/preempt=%b, expected %b", name, act, exp);
  endtask

  // Drive req, let one rising edge happen, compare at the falling edge.
  task automatic step(input string name, input logic [3:0] r,
                      input logic [3:0] g, input logic [1:0] o, input logic p);
    exp_t e;
    exp_q.push_back('{g: g, o: o, p: p});
    req = r;
    @(posedge clk);
    @(negedge clk);
    e = exp_q.pop_front();
    check(name, {grnt, owner_id, bus_busy, preempt}, {e.g, e.o, |e.g, e.p});
  endtask

  task automatic do_reset();
    #1 reset = 1'b0;
    req = 4'b0000;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [1:0] cur;
    logic [1:0] o5;
    logic       p5;

    passed = 0;
    total  = 0;
    // Sequence starting from OWN by master 0 with rr_ptr = 0.
    tbl[0]  = '{4'b0000, 4'b0000, 2'd0};  // drop -> idle, rr_ptr=1
    tbl[1]  = '{4'b0110, 4'b0010, 2'd1};  // pick from 1
    tbl[2]  = '{4'b0100, 4'b0100, 2'd2};  // direct hand-off, no zero cycle
    tbl[3]  = '{4'b0000, 4'b0000, 2'd2};  // idle keeps owner_id
    tbl[4]  = '{4'b1000, 4'b1000, 2'd3};
    tbl[5]  = '{4'b1000, 4'b1000, 2'd3};
    tbl[6]  = '{4'b0000, 4'b0000, 2'd3};  // rr_ptr wraps to 0
    tbl[7]  = '{4'b1001, 4'b0001, 2'd0};
    tbl[8]  = '{4'b1011, 4'b0001, 2'd0};  // new requests do not disturb owner
    tbl[9]  = '{4'b1010, 4'b0010, 2'd1};
    tbl[10] = '{4'b1001, 4'b1000, 2'd3};  // skip 2, take 3
    tbl[11] = '{4'b0001, 4'b0001, 2'd0};
    tbl[12] = '{4'b0000, 4'b0000, 2'd0};
    tbl[13] = '{4'b0001, 4'b0001, 2'd0};  // scan wraps all the way to 0
    tbl[14] = '{4'b0011, 4'b0001, 2'd0};
    tbl[15] = '{4'b0010, 4'b0010, 2'd1};
    tbl[16] = '{4'b0000, 4'b0000, 2'd1};
    tbl[17] = '{4'b0011, 4'b0001, 2'd0};  // rr_ptr=2, wraps to 0
    tbl[18] = '{4'b0000, 4'b0000, 2'd0};

    reset = 1'b1;
    req   = 4'b0000;
    #2 reset = 1'b0;
    req = 4'b1111;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("reset_state", {grnt, owner_id, bus_busy, preempt}, 8'b0000_00_0_0);
    reset = 1'b1;
    step("first_grant", 4'b1111, 4'b0001, 2'd0, 1'b0);

    for (int i = 0; i < 19; i++)
      step($sformatf("tbl%0d", i), tbl[i].req, tbl[i].g, tbl[i].o, 1'b0);

    // Asynchronous reset while the bus is owned.
    step("own_before_rst", 4'b0001, 4'b0001, 2'd0, 1'b0);
    step("own_hold", 4'b0101, 4'b0001, 2'd0, 1'b0);
    #1 reset = 1'b0;
    #1 check("async_reset", {grnt, owner_id, bus_busy, preempt}, 8'b0000_00_0_0);
    req = 4'b0000;
    @(negedge clk);
    reset = 1'b1;

    // All masters requesting; each owner drops for one edge after 3 cycles.
    cur = 2'd0;
    step("rot_start", 4'b1111, 4'b0001, 2'd0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step("rot_hold", 4'b1111, 4'b0001 << cur, cur, 1'b0);
      step("rot_hold", 4'b1111, 4'b0001 << cur, cur, 1'b0);
      step("rot_next", 4'b1111 & ~(4'b0001 << cur), 4'b0001 << (cur + 2'd1), cur + 2'd1, 1'b0);
      cur = cur + 2'd1;
    end

    // Two masters holding requests for a long time.
    do_reset();
    for (int j = 0; j < 40; j++) begin
`ifdef ARB_TIMEOUT_EN
      o5 = 2'((j / 16) % 2);
      p5 = (j > 0) && (j % 16 == 0);
`else
      o5 = 2'd0;
      p5 = 1'b0;
`endif
      step($sformatf("long_hold%0d", j), 4'b0011, 4'b0001 << o5, o5, p5);
    end
    // Sole requester is never preempted.
    for (int j = 0; j < 20; j++)
      step($sformatf("sole%0d", j), 4'b0001, 4'b0001, 2'd0, 1'b0);
    step("final_idle", 4'b0000, 4'b0000, 2'd0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
